// File: rtl/keypad_scanner.sv
// Keypad scanner for a 4x4 hex keypad. Walks four active-low column strobes in the
// same rotation as the display digit selector. It synchronizes and debounces the
// active-low row returns and shifts each accepted key code into a 32-bit entry
// register.
//
// Ports:
//   clock     system clock
//   reset     asynchronous, active-low reset
//   row_in    keypad rows, active-low, asynchronous to clock
//   clr       synchronous clear of value
//   col_out   column strobes, active-low one-hot (all high until the first tick)
//   key_code  code (4*row + col) of the last accepted key
//   key_valid one-clock pulse per accepted key
//   value     entry register, newest digit in [3:0]
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,  // clocks per column dwell, >= 4
  parameter int unsigned DEBOUNCE = 4      // consecutive ticks to accept/release, 1..15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  row_in,
  input  logic        clr,
  output logic [3:0]  col_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [31:0] value
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
  localparam logic [3:0] DebMax = 4'(DEBOUNCE);

  typedef enum logic [1:0] {StScan, StConfirm, StHold} state_e;

  state_e          state_q, state_d;
  logic [3:0]      sync1_q, row_s_q;
  logic [CntW-1:0] tick_cnt_q;
  logic [3:0]      col_q, col_d;
  logic [3:0]      cand_q, cand_d;
  logic [3:0]      dcnt_q, dcnt_d;
  logic [3:0]      key_code_q;
  logic            key_valid_q;
  logic [31:0]     value_q;

  logic       tick;
  logic       row_any;
  logic [1:0] row_idx, col_idx;
  logic [3:0] code, col_next, dcnt_inc, acc_code;
  logic       accept;

  assign tick = (tick_cnt_q == CntMax);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 4'b1111;
      row_s_q    <= 4'b1111;
      tick_cnt_q <= '0;
    end else begin
      sync1_q    <= row_in;
      row_s_q    <= sync1_q;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
    end
  end

  // Lowest row index wins when several rows are low.
  always_comb begin
    row_any = (row_s_q != 4'b1111);
    if (!row_s_q[3])      row_idx = 2'd0;
    else if (!row_s_q[2]) row_idx = 2'd1;
    else if (!row_s_q[1]) row_idx = 2'd2;
    else                  row_idx = 2'd3;
    case (col_q)
      4'b1011: col_idx = 2'd1;
      4'b1101: col_idx = 2'd2;
      4'b1110: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
    code = {row_idx, col_idx};
    // The idle all-high pattern joins the rotation at column 0.
    case (col_q)
      4'b0111: col_next = 4'b1011;
      4'b1011: col_next = 4'b1101;
      4'b1101: col_next = 4'b1110;
      default: col_next = 4'b0111;
    endcase
    dcnt_inc = dcnt_q + 4'd1;
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    cand_d   = cand_q;
    dcnt_d   = dcnt_q;
    accept   = 1'b0;
    acc_code = cand_q;
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (!row_any || col_q == 4'b1111) begin
            col_d = col_next;
          end else begin
            cand_d = code;
            if (DebMax == 4'd1) begin
              accept   = 1'b1;
              acc_code = code;
              dcnt_d   = 4'd0;
              state_d  = StHold;
            end else begin
              dcnt_d  = 4'd1;
              state_d = StConfirm;
            end
          end
        end
        StConfirm: begin
          if (row_any && code == cand_q) begin
            if (dcnt_inc == DebMax) begin
              accept  = 1'b1;
              dcnt_d  = 4'd0;
              state_d = StHold;
            end else begin
              dcnt_d = dcnt_inc;
            end
          end else begin
            dcnt_d  = 4'd0;
            col_d   = col_next;
            state_d = StScan;
          end
        end
        StHold: begin
          // Any low row, even a different key, restarts the release count.
          if (row_any) begin
            dcnt_d = 4'd0;
          end else if (dcnt_inc == DebMax) begin
            dcnt_d  = 4'd0;
            col_d   = col_next;
            state_d = StScan;
          end else begin
            dcnt_d = dcnt_inc;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StScan;
      col_q       <= 4'b1111;
      cand_q      <= 4'd0;
      dcnt_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      value_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cand_q      <= cand_d;
      dcnt_q      <= dcnt_d;
      key_valid_q <= accept;
      if (accept) key_code_q <= acc_code;
      // clr takes priority over a coincident shift.
      if (clr)         value_q <= 32'd0;
      else if (accept) value_q <= {value_q[27:0], acc_code};
    end
  end

  assign col_out   = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign value     = value_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=2). A keypad model pulls the pressed
// key's row low while its column is strobed. Stimulus pushes expected pulses into a
// queue; a monitor pops and compares on every key_valid.
module tb_keypad_scanner;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  row_in;
  logic        clr;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [31:0] value;

  logic       key_down = 1'b0;
  logic [1:0] key_r = 2'd0;
  logic [1:0] key_c = 2'd0;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] value;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] exp_value = 32'd0;
  int          checks = 0;
  int          failures = 0;
  int          npulses = 0;
  int          exp_pulses = 0;

  always #5 clock = ~clock;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE(2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .row_in   (row_in),
    .clr      (clr),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .value    (value)
  );

  function automatic logic [3:0] colpat(input logic [1:0] c);
    logic [3:0] one;
    one = 4'b1000;
    return ~(one >> c);
  endfunction

  assign row_in = (key_down && col_out == colpat(key_c)) ? colpat(key_r) : 4'b1111;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (reset === 1'b1 && key_valid === 1'b1) begin
      npulses++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: key_code=%h value=%h, required no pulse",
                 key_code, value);
      end else begin
        e = exp_q.pop_front();
        check("pulse_key_code", 32'(key_code), 32'(e.code));
        check("pulse_value", value, e.value);
      end
    end
  end

  task automatic wait_col(input logic [3:0] pat);
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      if (col_out == pat) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_col: col_out=%b never reached %b", col_out, pat);
  endtask

  task automatic wait_col_not(input logic [3:0] pat);
    if (col_out != pat) return;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      if (col_out != pat) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_col_not: col_out stuck at %b", col_out);
  endtask

  task automatic wait_pulse();
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      if (key_valid) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_pulse: key_valid=0 after 200 clocks, required a pulse");
  endtask

  // Press a key starting away from its column, so that T is the edge that strobes it.
  task automatic start_press(input logic [3:0] code, input bit expect_pulse);
    wait_col_not(colpat(code[1:0]));
    key_r    = code[3:2];
    key_c    = code[1:0];
    key_down = 1'b1;
    if (expect_pulse) begin
      exp_value = {exp_value[27:0], code};
      exp_q.push_back({code, exp_value});
      exp_pulses++;
    end
    wait_col(colpat(code[1:0]));
  endtask

  task automatic release_key();
    key_down = 1'b0;
    repeat (16) @(posedge clock);
    #1;
  endtask

  task automatic press_key(input logic [3:0] code);
    start_press(code, 1'b1);
    wait_pulse();
    repeat (8) @(posedge clock);
    #1;
    release_key();
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] seq [4];
    seq = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};
    reset = 1'b0;
    clr   = 1'b0;

    // 1. reset values and idle rotation
    repeat (3) @(posedge clock);
    #1;
    check("rst_col_out", 32'(col_out), 32'h0000_000F);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_value", value, 32'h0);
    check("rst_key_code", 32'(key_code), 32'h0);
    release_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("idle_col_before_tick", 32'(col_out), 32'h0000_000F);
    end
    @(posedge clock);
    #1;
    check("first_tick_col", 32'(col_out), 32'h0000_0007);
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(posedge clock);
      #1;
      check("rotation_col", 32'(col_out), 32'(seq[i]));
    end
    check("idle_value", value, 32'h0);

    // 2. key 6 held, then released
    start_press(4'h6, 1'b1);
    wait_pulse();
    check("hold_col_frozen", 32'(col_out), 32'h0000_000D);
    repeat (80) @(posedge clock);
    #1;
    check("hold_col_after_20_ticks", 32'(col_out), 32'h0000_000D);
    release_key();
    checks++;
    if (col_out == 4'b1101) begin
      failures++;
      $display("FAIL release_resume: col_out=%b, required scanning past 1101", col_out);
    end

    // 3. bounce on key 1: low for one tick only
    start_press(4'h1, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    check("bounce_col_frozen", 32'(col_out), 32'h0000_000B);
    key_down = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("bounce_col_advanced", 32'(col_out), 32'h0000_000D);
    repeat (8) @(posedge clock);

    // 4. codes 1..8 then F
    for (int k = 1; k <= 8; k++) press_key(4'(k));
    press_key(4'hF);
    check("nine_press_value", value, 32'h2345_678F);

    // 5a. clr coincident with acceptance of A (accept edge is T+8)
    start_press(4'hA, 1'b0);
    exp_value = 32'd0;
    exp_q.push_back({4'hA, 32'd0});
    exp_pulses++;
    repeat (7) @(posedge clock);
    #1;
    clr = 1'b1;
    @(posedge clock);
    #1;
    clr = 1'b0;
    check("clr_accept_valid", 32'(key_valid), 32'h1);
    check("clr_accept_value", value, 32'h0);
    check("clr_accept_code", 32'(key_code), 32'h0000_000A);
    repeat (8) @(posedge clock);
    #1;
    release_key();
    press_key(4'h5);
    check("press5_value", value, 32'h0000_0005);
    check("code_held_between_pulses", 32'(key_code), 32'h0000_0005);

    // 6a. reset during CONFIRM on key 7
    start_press(4'h7, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("rst_confirm_col", 32'(col_out), 32'h0000_000F);
    check("rst_confirm_valid", 32'(key_valid), 32'h0);
    check("rst_confirm_value", value, 32'h0);
    key_down  = 1'b0;
    exp_value = 32'd0;
    repeat (2) @(posedge clock);
    release_reset();
    repeat (40) @(posedge clock);
    #1;

    // 6b. reset during HOLD on key 3
    start_press(4'h3, 1'b1);
    wait_pulse();
    repeat (4) @(posedge clock);
    #1;
    check("pre_rst_hold_value", value, 32'h0000_0003);
    reset = 1'b0;
    #1;
    check("rst_hold_col", 32'(col_out), 32'h0000_000F);
    check("rst_hold_valid", 32'(key_valid), 32'h0);
    check("rst_hold_value", value, 32'h0);
    check("rst_hold_code", 32'(key_code), 32'h0);
    key_down  = 1'b0;
    exp_value = 32'd0;
    repeat (2) @(posedge clock);
    release_reset();
    repeat (40) @(posedge clock);
    #1;

    // 5b. clr on its own
    press_key(4'h9);
    check("press9_value", value, 32'h0000_0009);
    @(negedge clock);
    clr = 1'b1;
    @(posedge clock);
    #1;
    clr = 1'b0;
    exp_value = 32'd0;
    check("clr_alone_value", value, 32'h0);

    repeat (8) @(posedge clock);
    check("pulse_count", 32'(npulses), 32'(exp_pulses));
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 4-digit display driver. It drives four active-low column strobes in the same rotation as the display digit selector and samples four active-low row returns from a 4x4 hex keypad.
- Each row sample is synchronized and debounced. Each accepted press yields one 4-bit key code and is shifted into a 32-bit entry register.
- The entry register feeds the display/counter logic, for example as a preload value.

Parameters:
- SCAN_DIV, 1000, clocks per column dwell; legal values are 4 or more.
- DEBOUNCE, 4, consecutive identical ticks required to accept a press or a release; legal values are 1 to 15.

Ports:
- clock  input  1  system clock
- reset  input  1  reset, asynchronous, active-low
- row_in  input  4  keypad rows, active-low, asynchronous to clock
- clr  input  1  synchronous clear of value
- col_out  output  4  column strobes, active-low one-hot
- key_code  output  4  code of the last accepted key
- key_valid  output  1  one-clock pulse per accepted key
- value  output  32  entry register; newest digit in [3:0]

Behaviour:
- Reset values: col_out=4'b1111, key_code=0, key_valid=0, value=0, state=SCAN, tick counter=0, debounce counter=0, synchronizer=4'b1111. Reset mid-press aborts the press with no pulse.
- Synchronizer: row_in passes through two flops, giving row_s.
- Tick generator:
  - A counter runs 0..SCAN_DIV-1 and wraps.
  - "tick" is the cycle the counter equals SCAN_DIV-1.
  - All state decisions occur only on tick.
- Column rotation on each advance: 1111->0111->1011->1101->1110->0111.
  - Column index c: 0111=0, 1011=1, 1101=2, 1110=3.
  - The first tick after reset advances from 1111 to 0111 without sampling.
- Row index r: row_s[3] low is r=0, row_s[0] low is r=3. If several rows are low, the lowest r wins.
- Encoding: code = 4*r + c, 4-bit.
- State SCAN, on tick:
  - If row_s is 4'b1111 or col_out is 4'b1111: advance the column.
  - Otherwise: cand <= code, dcnt <= 1, column frozen, go to CONFIRM.
  - If DEBOUNCE=1, accept immediately as described under CONFIRM.
- State CONFIRM, on tick, with the column frozen:
  - If a row is low and code==cand: dcnt++.
  - When dcnt reaches DEBOUNCE: accept.
    - key_valid=1 for exactly one clock, on the cycle after the tick.
    - key_code<=cand.
    - value<={value[27:0],cand}.
    - dcnt<=0, go to HOLD.
  - If no row is low, or code!=cand: go to SCAN and advance the column. No pulse.
- State HOLD, on tick, with the column frozen:
  - If row_s==4'b1111: dcnt++; when it reaches DEBOUNCE, go to SCAN and advance the column.
  - Any low row resets dcnt to 0, including a different key pressed while held. No repeat and no second pulse until full release.
- clr:
  - Sets value to 0 on the next clock, in any state.
  - If clr coincides with an acceptance, clr wins: value=0, but key_valid and key_code still update.
- Wrap: value shifts out its top nibble silently; there is no overflow flag.
- key_code holds its value between pulses.

Test Plan (SCAN_DIV=4, DEBOUNCE=2):
1. Reset released, no keys -> col_out is 1111 until the first tick, then cycles 0111,1011,1101,1110 changing every 4 clocks; key_valid never asserts; value=0.
2. Hold row_in=4'b1011 (r=1) while col_out=1101 (c=2), and drive row_in=1111 for other columns -> column freezes at 1101; after 2 confirming ticks, one key_valid pulse with key_code=4'h6 and value=32'h0000_0006; held for 20 ticks, no further pulse; released, scanning resumes after 2 release ticks.
3. Bounce: row low for 1 tick then high before the second tick -> no pulse, state returns to SCAN, column advances to the next position.
4. Eight presses of codes 1..8, then a ninth press of code F -> value=32'h2345_678F after the ninth pulse.
5. clr asserted on the same cycle as an acceptance of code 4'hA -> value=0, key_code=4'hA, key_valid pulses once; with clr not coinciding, value=0 the cycle after clr.
6. Reset asserted during CONFIRM, and during HOLD -> all outputs return to reset values immediately (col_out=1111, key_valid=0, value=0); no pulse after release of reset until a fresh debounced press.
